aes_round_ctrl: RTL and testbench

Sequencer for AES-128 encryption around the shared round datapath (SubBytes → ShiftRows → registered MixColumns). It accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey. It then issues the state to the external datapath once per round for 10 rounds, with MixColumns bypassed in round 10. After each round it applies AddRoundKey with an on-the-fly expanded key and presents the ciphertext on an output valid/ready handshake.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_round_ctrl_if.sv | 23 ++
 rtl/aes_key_step.sv | 29 ++
 rtl/aes_round_ctrl.sv | 101 ++++++++++
 tb/tb_aes_round_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: round count, S-box, round constants and
// the encoding of the round-control FSM.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } fsm_e;

    // Byte 0x00 maps to the top byte, byte 0xff to the bottom byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Plaintext/key input and ciphertext output handshakes of the
// AES round controller.
interface aes_round_ctrl_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: RotWord, SubWord, rcon and the
// chained XOR across the four words.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rc,
    output logic [127:0] key_next
);

    logic [31:0] w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w3 = key[31:0];

    assign t = {sbox(w3[23:16]) ^ rc,
                sbox(w3[15:8]),
                sbox(w3[7:0]),
                sbox(w3[31:24])};

    assign n0 = key[127:96] ^ t;
    assign n1 = key[95:64] ^ n0;
    assign n2 = key[63:32] ^ n1;
    assign n3 = w3 ^ n2;

    assign key_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer around an external SubBytes/ShiftRows/
// MixColumns datapath with fixed latency DP_LAT.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int DP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_ctrl_if.slave  bus,
    output logic             dp_valid,
    output logic [127:0]     dp_state,
    output logic             dp_last,
    input  logic [127:0]     dp_result
);

    localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    fsm_e          fsm;
    logic [3:0]    round;
    logic [127:0]  state_r;
    logic [127:0]  rkey_r;
    logic [127:0]  key_next;
    logic [7:0]    rc;
    logic [CW-1:0] cnt;
    logic          in_rdy_r;
    logic          out_vld_r;

    assign rc = rcon(round);

    aes_key_step u_key (
        .key      (rkey_r),
        .rc       (rc),
        .key_next (key_next)
    );

    assign bus.in_ready  = in_rdy_r;
    assign bus.out_valid = out_vld_r;
    assign bus.out_block = state_r;
    assign dp_state      = state_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            round     <= 4'd0;
            state_r   <= '0;
            rkey_r    <= '0;
            cnt       <= '0;
            in_rdy_r  <= 1'b1;
            out_vld_r <= 1'b0;
            dp_valid  <= 1'b0;
            dp_last   <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_r  <= bus.in_block ^ bus.in_key;
                        rkey_r   <= bus.in_key;
                        round    <= 4'd1;
                        in_rdy_r <= 1'b0;
                        dp_valid <= 1'b1;
                        dp_last  <= 1'b0;
                        fsm      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Key for this round is ready by the time the result returns.
                    rkey_r   <= key_next;
                    cnt      <= CW'(DP_LAT - 1);
                    dp_valid <= 1'b0;
                    dp_last  <= 1'b0;
                    fsm      <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state_r <= dp_result ^ rkey_r;
                        if (round == NR) begin
                            out_vld_r <= 1'b1;
                            fsm       <= DONE;
                        end else begin
                            round    <= round + 4'd1;
                            dp_valid <= 1'b1;
                            dp_last  <= (round == NR - 4'd1);
                            fsm      <= ISSUE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_vld_r <= 1'b0;
                        in_rdy_r  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomized and FIPS-197 vector bench for aes_round_ctrl at
// DP_LAT=1 and DP_LAT=3 against a full-AES reference model.
module tb_aes_round_ctrl;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_R1  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    int           sel;
    logic         iv;
    logic         ordy;
    logic [127:0] ib;
    logic [127:0] ik;

    aes_round_ctrl_if ifa ();
    aes_round_ctrl_if ifb ();

    logic         dva, dla, dvb, dlb;
    logic [127:0] dsa, dra, dsb, drb;
    logic [127:0] pa [1];
    logic [127:0] pb [3];

    logic         rdy, ov, dv, dl;
    logic [127:0] ob, ds;

    logic [7:0]   tsb [256];
    int           n_tests;
    int           n_fail;
    int           cyc [2];
    int           t_acc [2];
    int           npulse [2];
    bit           pend [2];
    bit           pov [2];
    logic [127:0] exp_ct [2];
    logic [127:0] exp_r1 [2];

    aes_round_ctrl #(.DP_LAT(1)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifa),
        .dp_valid  (dva),
        .dp_state  (dsa),
        .dp_last   (dla),
        .dp_result (dra)
    );

    aes_round_ctrl #(.DP_LAT(3)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifb),
        .dp_valid  (dvb),
        .dp_state  (dsb),
        .dp_last   (dlb),
        .dp_result (drb)
    );

    assign ifa.in_valid  = iv && (sel == 0);
    assign ifb.in_valid  = iv && (sel == 1);
    assign ifa.in_block  = ib;
    assign ifb.in_block  = ib;
    assign ifa.in_key    = ik;
    assign ifb.in_key    = ik;
    assign ifa.out_ready = ordy && (sel == 0);
    assign ifb.out_ready = ordy && (sel == 1);

    assign rdy = (sel == 0) ? ifa.in_ready  : ifb.in_ready;
    assign ov  = (sel == 0) ? ifa.out_valid : ifb.out_valid;
    assign ob  = (sel == 0) ? ifa.out_block : ifb.out_block;
    assign dv  = (sel == 0) ? dva : dvb;
    assign dl  = (sel == 0) ? dla : dlb;
    assign ds  = (sel == 0) ? dsa : dsb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse then the affine map.
    function automatic logic [7:0] mk_sb(input int i);
        logic [7:0] v;
        logic [7:0] inv;
        v = 8'(i);
        inv = 8'h00;
        if (i != 0) begin
            inv = 8'h01;
            repeat (254) inv = gmul(inv, v);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] dp_round(input logic [127:0] st, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   s [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = tsb[st[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                s[w+4*c] = a[w+4*((c+w)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                c0 = s[4*c]; c1 = s[4*c+1]; c2 = s[4*c+2]; c3 = s[4*c+3];
                s[4*c]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
                s[4*c+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
                s[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
                s[4*c+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] st;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {tsb[t[23:16]], tsb[t[15:8]], tsb[t[7:0]], tsb[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        st = pt ^ key;
        for (int r = 1; r <= 10; r++)
            st = dp_round(st, r == 10) ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return st;
    endfunction

    always @(posedge clk) pa[0] <= dva ? dp_round(dsa, dla) : rnd128();

    always @(posedge clk) begin
        pb[0] <= dvb ? dp_round(dsb, dlb) : rnd128();
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    assign dra = pa[0];
    assign drb = pb[2];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic r,
                       input logic [127:0] b, input logic [127:0] k,
                       input logic ovl, input logic ordl, input logic [127:0] obl,
                       input logic dvl, input logic dll, input logic [127:0] dsl);
        int lat;
        lat = 1 + 10 * ((id == 0 ? 1 : 3) + 1);
        cyc[id]++;
        if (!rst_n) begin
            pend[id] = 0;
            pov[id] = 0;
            npulse[id] = 0;
            return;
        end
        chk($sformatf("in_ready%0d", id), 128'(r), 128'(!pend[id]));
        if (dvl) begin
            npulse[id]++;
            chk($sformatf("dp_last%0d", id), 128'(dll), 128'(npulse[id] == 10));
            if (npulse[id] == 1)
                chk($sformatf("first_state%0d", id), dsl, exp_r1[id]);
        end else begin
            chk($sformatf("dp_last_idle%0d", id), 128'(dll), 128'(0));
        end
        if (ovl && !pov[id])
            chk($sformatf("latency%0d", id), 128'(cyc[id] - t_acc[id]), 128'(lat));
        pov[id] = ovl;
        if (ovl && ordl) begin
            if (!pend[id]) begin
                chk($sformatf("spurious_out%0d", id), 128'(1), 128'(0));
            end else begin
                chk($sformatf("ct%0d", id), obl, exp_ct[id]);
                chk($sformatf("rounds%0d", id), 128'(npulse[id]), 128'(10));
                pend[id] = 0;
            end
        end
        if (v && r) begin
            pend[id] = 1;
            exp_ct[id] = aes_ref(b, k);
            exp_r1[id] = b ^ k;
            t_acc[id] = cyc[id];
            npulse[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.in_valid, ifa.in_ready, ifa.in_block, ifa.in_key,
            ifa.out_valid, ifa.out_ready, ifa.out_block, dva, dla, dsa);
        mon(1, ifb.in_valid, ifb.in_ready, ifb.in_block, ifb.in_key,
            ifb.out_valid, ifb.out_ready, ifb.out_block, dvb, dlb, dsb);
    end

    task automatic send(input logic [127:0] b, input logic [127:0] k);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        iv = 1'b1;
        ib = b;
        ik = k;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        iv = 1'b0;
    endtask

    task automatic wait_out();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ov) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("out_timeout", 128'(0), 128'(1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ov"}, 128'(ov), 128'(0));
        chk({tag, "_dv"}, 128'(dv), 128'(0));
        chk({tag, "_dl"}, 128'(dl), 128'(0));
        chk({tag, "_ds"}, ds, 128'(0));
        chk({tag, "_ob"}, ob, 128'(0));
    endtask

    task automatic run_all();
        logic [127:0] b, k, b2, k2, e;
        int n;
        int st;
        rst_n = 1'b0;
        iv = 1'b0;
        ordy = 1'b1;
        @(negedge clk);
        chk_zero("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 128'(rdy), 128'(1));

        send(B_PT, B_KEY);
        @(negedge clk);
        chk("b_dv1", 128'(dv), 128'(1));
        chk("b_r1_state", ds, B_R1);
        wait_out();
        chk("b_ct", ob, B_CT);
        @(posedge clk);
        #1;

        send(C_PT, C_KEY);
        wait_out();
        chk("c_ct", ob, C_CT);
        @(posedge clk);
        #1;

        ordy = 1'b0;
        b = rnd128();
        k = rnd128();
        e = aes_ref(b, k);
        send(b, k);
        wait_out();
        for (int i = 0; i < 50; i++) begin
            chk("bp_ov", 128'(ov), 128'(1));
            chk("bp_ob", ob, e);
            chk("bp_rdy", 128'(rdy), 128'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 ordy = 1'b1;
        @(negedge clk);
        chk("bp_last_ov", 128'(ov), 128'(1));
        @(negedge clk);
        chk("bp_idle_rdy", 128'(rdy), 128'(1));
        chk("bp_idle_ov", 128'(ov), 128'(0));

        b = rnd128();
        k = rnd128();
        b2 = rnd128();
        k2 = rnd128();
        send(b, k);
        iv = 1'b1;
        ib = b2;
        ik = k2;
        wait_out();
        chk("busy_ct", ob, aes_ref(b, k));
        chk("busy_rdy0", 128'(rdy), 128'(0));
        @(negedge clk);
        chk("busy_rdy1", 128'(rdy), 128'(1));
        chk("busy_ov0", 128'(ov), 128'(0));
        @(negedge clk);
        chk("busy_dv", 128'(dv), 128'(1));
        chk("busy_state", ds, b2 ^ k2);
        @(posedge clk);
        #1 iv = 1'b0;
        wait_out();
        chk("busy_ct2", ob, aes_ref(b2, k2));
        @(posedge clk);
        #1;

        send(B_PT, B_KEY);
        n = 0;
        for (int i = 0; i < 200 && n < 5; i++) begin
            @(negedge clk);
            if (dv) n++;
        end
        chk("mid_round5", 128'(n), 128'(5));
        #1 rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(B_PT, B_KEY);
        wait_out();
        chk("post_rst_ct", ob, B_CT);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            b = rnd128();
            k = rnd128();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(b, k);
            st = $urandom_range(0, 6);
            ordy = (st == 0);
            wait_out();
            chk("rnd_ct", ob, aes_ref(b, k));
            if (st > 0) begin
                repeat (st) @(posedge clk);
                #1 ordy = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 0;
            t_acc[i] = 0;
            npulse[i] = 0;
            pend[i] = 0;
            pov[i] = 0;
            exp_ct[i] = '0;
            exp_r1[i] = '0;
        end
        for (int i = 0; i < 256; i++) tsb[i] = mk_sb(i);
        sel = 0;
        iv = 1'b0;
        ordy = 1'b1;
        ib = '0;
        ik = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            run_all();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
